// File: rtl/wb_ram_arbiter_pkg.sv
// Shared types for the 2:1 Wishbone RAM arbiter.
// Grant states are one-hot, so the state register doubles as grant_o.
package wb_ram_arbiter_pkg;

    localparam int WDOG_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_e;

endpackage

// File: rtl/wb_ram_arbiter_watchdog.sv
// Bus watchdog: counts strobed cycles without ack and flags a timeout.
// A same-cycle ack always suppresses the fire.
module wb_watchdog
    import wb_ram_arbiter_pkg::*;
#(
    parameter int W       = WDOG_W,
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic ack,
    output logic fire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || ack) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign fire = en && !ack && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_ram_arbiter.sv
// 2:1 Wishbone classic arbiter sharing one RAM slave between fetch (m0) and
// load/store (m1); grant is locked per bus cycle, round-robin on ties.
module wb_ram_arbiter
    import wb_ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic [ADDR_WIDTH-3:0] m0_adr_i,
    input  logic [31:0]           m0_dat_i,
    output logic [31:0]           m0_dat_o,
    input  logic                  m0_we_i,
    input  logic [3:0]            m0_sel_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_cyc_i,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic [ADDR_WIDTH-3:0] m1_adr_i,
    input  logic [31:0]           m1_dat_i,
    output logic [31:0]           m1_dat_o,
    input  logic                  m1_we_i,
    input  logic [3:0]            m1_sel_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_cyc_i,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic [ADDR_WIDTH-3:0] s_adr_o,
    output logic [31:0]           s_dat_o,
    input  logic [31:0]           s_dat_i,
    output logic                  s_we_o,
    output logic [3:0]            s_sel_o,
    output logic                  s_stb_o,
    output logic                  s_cyc_o,
    input  logic                  s_ack_i,
    output logic [1:0]            grant_o
);

    state_e state;
    logic   last_grant;   // 0 = m0 was last served, 1 = m1
    logic   active, sel1, mx_cyc, mx_stb, fire, rel;

    assign active = (state != IDLE);
    assign sel1   = (state == G1);
    assign mx_cyc = sel1 ? m1_cyc_i : m0_cyc_i;
    assign mx_stb = sel1 ? m1_stb_i : m0_stb_i;
    assign rel    = active && (!mx_cyc || fire);

    // Clearing while idle or releasing means the count is 0 on every grant entry.
    wb_watchdog #(.W(WDOG_W), .TIMEOUT(TIMEOUT)) u_wdog (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .clr   (!active || rel),
        .en    (active && mx_stb),
        .ack   (s_ack_i),
        .fire  (fire)
    );

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_cyc_i && m1_cyc_i) state <= last_grant ? G0 : G1;
                    else if (m0_cyc_i)        state <= G0;
                    else if (m1_cyc_i)        state <= G1;
                end
                G0: if (rel) begin
                    last_grant <= 1'b0;
                    state      <= m1_cyc_i ? G1 : IDLE;
                end
                G1: if (rel) begin
                    last_grant <= 1'b1;
                    state      <= m0_cyc_i ? G0 : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign grant_o = state;

    assign s_adr_o = sel1 ? m1_adr_i : m0_adr_i;
    assign s_dat_o = sel1 ? m1_dat_i : m0_dat_i;
    assign s_sel_o = sel1 ? m1_sel_i : m0_sel_i;
    assign s_we_o  = active && (sel1 ? m1_we_i : m0_we_i);
    assign s_cyc_o = active && mx_cyc;
    assign s_stb_o = active && mx_stb && !fire;

    // Acks seen while idle or routed to the other master are simply dropped.
    assign m0_ack_o = wb_rst_ni && (state == G0) && s_ack_i;
    assign m1_ack_o = wb_rst_ni && (state == G1) && s_ack_i;
    assign m0_err_o = wb_rst_ni && (state == G0) && fire;
    assign m1_err_o = wb_rst_ni && (state == G1) && fire;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule
